uart_rx_fifo: RTL and testbench

- Parametrised UART receiver with 16x oversampling, configurable frame format (data bits, parity, stop bits) and an output FIFO.
- Successor to the fixed 8N1 receive path behind uart_txd_in on the Arty A7 top. Sits between the pin and the consumer logic.
- Presents received bytes on a valid/ready stream and reports line errors as one-cycle pulses.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/uart_rx_fifo.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART receive path
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Rounded clocks per 16x oversample tick.
    function automatic int calc_div(input int clk_hz, input int baud);
        longint c;
        longint b;
        c = longint'(clk_hz);
        b = longint'(baud);
        return int'((c + b * 8) / (b * 16));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (fill == '0);
    assign full    = (fill == FW'(DEPTH));
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            fill <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampling UART receiver feeding an output FIFO
import uart_pkg::*;

module uart_rx_fifo #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          parity_err,
    output logic                          framing_err,
    output logic                          overrun
);
    localparam int      DIV      = calc_div(CLK_HZ, BAUD);
    localparam int      CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam parity_e PAR_MODE = parity_e'(PARITY[1:0]);

    if (DIV < 1) begin : g_div_check
        $error("uart_rx_fifo: clock too slow for 16x oversampling at this baud rate");
    end

    logic rxd_meta, rxd_s, rxd_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {rxd_meta, rxd_s, rxd_d} <= 3'b111;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_d    <= rxd_s;
        end
    end

    logic [CW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    rx_state_e            state, state_n;
    logic [3:0]           samp_cnt, samp_n;
    logic [3:0]           bit_cnt, bit_n;
    logic                 stop_cnt, stop_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_bad, par_bad_n;
    logic                 push_req, ferr_n, perr_n;
    logic                 exp_par;
    logic                 fifo_empty, fifo_full, pop;
    logic [DATA_BITS-1:0] fifo_rdata;

    assign exp_par = (PAR_MODE == PAR_ODD) ? ~(^shreg) : (^shreg);

    always_comb begin
        state_n   = state;
        samp_n    = samp_cnt;
        bit_n     = bit_cnt;
        stop_n    = stop_cnt;
        shreg_n   = shreg;
        par_bad_n = par_bad;
        push_req  = 1'b0;
        ferr_n    = 1'b0;
        perr_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rxd_d && !rxd_s) begin
                    state_n = ST_START;
                    samp_n  = 4'd0;
                end
            end
            ST_START: begin
                if (tick) begin
                    samp_n = samp_cnt + 4'd1;
                    // Mid-bit check; realigning here puts later samples at bit centres.
                    if (samp_cnt == 4'd7) begin
                        samp_n = 4'd0;
                        if (rxd_s) begin
                            state_n = ST_IDLE;
                        end else begin
                            state_n   = ST_DATA;
                            bit_n     = 4'd0;
                            par_bad_n = 1'b0;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    samp_n = samp_cnt + 4'd1;
                    if (samp_cnt == 4'd15) begin
                        shreg_n = {rxd_s, shreg[DATA_BITS-1:1]};
                        bit_n   = bit_cnt + 4'd1;
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            state_n = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                            stop_n  = 1'b0;
                        end
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    samp_n = samp_cnt + 4'd1;
                    if (samp_cnt == 4'd15) begin
                        par_bad_n = (rxd_s != exp_par);
                        state_n   = ST_STOP;
                        stop_n    = 1'b0;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    samp_n = samp_cnt + 4'd1;
                    if (samp_cnt == 4'd15) begin
                        if (!rxd_s) begin
                            ferr_n  = 1'b1;
                            state_n = ST_BREAK;
                        end else if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            state_n = ST_IDLE;
                            if (par_bad) begin
                                perr_n = 1'b1;
                            end else begin
                                push_req = 1'b1;
                            end
                        end else begin
                            stop_n = 1'b1;
                        end
                    end
                end
            end
            ST_BREAK: begin
                if (tick && rxd_s) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            samp_cnt    <= 4'd0;
            bit_cnt     <= 4'd0;
            stop_cnt    <= 1'b0;
            shreg       <= '0;
            par_bad     <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            samp_cnt    <= samp_n;
            bit_cnt     <= bit_n;
            stop_cnt    <= stop_n;
            shreg       <= shreg_n;
            par_bad     <= par_bad_n;
            parity_err  <= perr_n;
            framing_err <= ferr_n;
            overrun     <= push_req && fifo_full && !pop;
        end
    end

    assign pop     = m_valid && m_ready;
    assign m_valid = !fifo_empty;
    assign m_data  = fifo_empty ? '0 : fifo_rdata;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .wdata (shreg_n),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .fill  (fill)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench for uart_rx_fifo in 8N1 and 8E1 configurations
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst, rxd, rxd_p, m_ready, m_ready_p;
    logic [7:0] m_data, m_data_p;
    logic       m_valid, m_valid_p;
    logic [4:0] fill, fill_p;
    logic       perr, ferr, ovr, perr_p, ferr_p, ovr_p;

    int tests = 0;
    int fails = 0;
    logic [7:0] got[$];
    logic [7:0] got_p[$];
    int n_valid, n_perr, n_ferr, n_ovr, np_perr, np_ferr, np_ovr;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_HZ(100_000_000), .BAUD(6_250_000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .fill(fill), .parity_err(perr), .framing_err(ferr),
        .overrun(ovr)
    );

    uart_rx_fifo #(.CLK_HZ(100_000_000), .BAUD(6_250_000), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_p (
        .clk(clk), .rst(rst), .rxd(rxd_p), .m_data(m_data_p), .m_valid(m_valid_p),
        .m_ready(m_ready_p), .fill(fill_p), .parity_err(perr_p), .framing_err(ferr_p),
        .overrun(ovr_p)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid) n_valid++;
            if (m_valid && m_ready) got.push_back(m_data);
            if (m_valid_p && m_ready_p) got_p.push_back(m_data_p);
            if (perr) n_perr++;
            if (ferr) n_ferr++;
            if (ovr) n_ovr++;
            if (perr_p) np_perr++;
            if (ferr_p) np_ferr++;
            if (ovr_p) np_ovr++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        got.delete();
        got_p.delete();
        n_valid = 0; n_perr = 0; n_ferr = 0; n_ovr = 0;
        np_perr = 0; np_ferr = 0; np_ovr = 0;
    endtask

    task automatic drive(input int sel, input logic v, input int n);
        if (sel == 0) rxd = v;
        else rxd_p = v;
        cyc(n);
    endtask

    // par < 0 means no parity bit; otherwise par[0] is the parity bit sent.
    task automatic send_frame(input int sel, input logic [7:0] data, input int par, input logic stop);
        drive(sel, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive(sel, data[i], 16);
        if (par >= 0) drive(sel, par[0], 16);
        drive(sel, stop, 16);
    endtask

    task automatic test_reset();
        rst = 1'b1; rxd = 1'b1; rxd_p = 1'b1; m_ready = 1'b0; m_ready_p = 1'b0;
        clear_mon();
        cyc(3);
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        tests++; if (fill !== 5'd0) begin fails++; $display("FAIL reset_fill: got %0d want 0", fill); end
        tests++; if ({perr, ferr, ovr} !== 3'b000) begin fails++; $display("FAIL reset_errs: got %b want 000", {perr, ferr, ovr}); end
        tests++; if ({m_valid_p, fill_p} !== 6'd0) begin fails++; $display("FAIL reset_par_inst: got %b want 0", {m_valid_p, fill_p}); end
        rst = 1'b0;
        cyc(5);
    endtask

    task automatic test_basic();
        m_ready = 1'b1;
        clear_mon();
        send_frame(0, 8'hA5, -1, 1'b1);
        drive(0, 1'b1, 20);
        tests++; if (got.size() != 1 || got[0] !== 8'hA5) begin fails++; $display("FAIL a5_data: got %0d words head %h, want 1 word a5", got.size(), (got.size() > 0) ? got[0] : 8'hxx); end
        tests++; if (n_valid != 1) begin fails++; $display("FAIL a5_valid_cycles: got %0d want 1", n_valid); end
        tests++; if (n_perr + n_ferr + n_ovr != 0) begin fails++; $display("FAIL a5_errs: got %0d pulses want 0", n_perr + n_ferr + n_ovr); end
    endtask

    task automatic test_glitch();
        clear_mon();
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 40);
        tests++; if (got.size() != 0 || n_valid != 0) begin fails++; $display("FAIL glitch_data: got %0d words %0d valid cycles want 0", got.size(), n_valid); end
        tests++; if (n_perr + n_ferr + n_ovr != 0) begin fails++; $display("FAIL glitch_errs: got %0d pulses want 0", n_perr + n_ferr + n_ovr); end
        send_frame(0, 8'h3C, -1, 1'b1);
        drive(0, 1'b1, 20);
        tests++; if (got.size() != 1 || got[0] !== 8'h3C) begin fails++; $display("FAIL glitch_next: got %0d words head %h, want 1 word 3c", got.size(), (got.size() > 0) ? got[0] : 8'hxx); end
    endtask

    task automatic test_framing();
        clear_mon();
        send_frame(0, 8'h55, -1, 1'b0);
        drive(0, 1'b0, 40);
        drive(0, 1'b1, 30);
        tests++; if (n_ferr != 1) begin fails++; $display("FAIL framing_pulse: got %0d cycles want 1", n_ferr); end
        tests++; if (n_perr + n_ovr != 0) begin fails++; $display("FAIL framing_other_errs: got %0d want 0", n_perr + n_ovr); end
        tests++; if (got.size() != 0 || n_valid != 0) begin fails++; $display("FAIL framing_no_data: got %0d words want 0", got.size()); end
        clear_mon();
        send_frame(0, 8'h81, -1, 1'b1);
        drive(0, 1'b1, 20);
        tests++; if (got.size() != 1 || got[0] !== 8'h81) begin fails++; $display("FAIL framing_next: got %0d words head %h, want 1 word 81", got.size(), (got.size() > 0) ? got[0] : 8'hxx); end
        tests++; if (n_ferr != 0) begin fails++; $display("FAIL framing_next_err: got %0d want 0", n_ferr); end
    endtask

    task automatic test_parity();
        m_ready_p = 1'b1;
        clear_mon();
        send_frame(1, 8'h07, 0, 1'b1);
        drive(1, 1'b1, 20);
        tests++; if (np_perr != 1) begin fails++; $display("FAIL parity_pulse: got %0d cycles want 1", np_perr); end
        tests++; if (fill_p !== 5'd0 || got_p.size() != 0) begin fails++; $display("FAIL parity_drop: fill %0d words %0d want 0", fill_p, got_p.size()); end
        tests++; if (np_ferr + np_ovr != 0) begin fails++; $display("FAIL parity_other_errs: got %0d want 0", np_ferr + np_ovr); end
        clear_mon();
        send_frame(1, 8'h07, 1, 1'b1);
        drive(1, 1'b1, 20);
        tests++; if (got_p.size() != 1 || got_p[0] !== 8'h07) begin fails++; $display("FAIL parity_good: got %0d words head %h, want 1 word 07", got_p.size(), (got_p.size() > 0) ? got_p[0] : 8'hxx); end
        tests++; if (np_perr != 0) begin fails++; $display("FAIL parity_good_err: got %0d want 0", np_perr); end
    endtask

    task automatic test_overrun();
        logic [7:0] v;
        m_ready = 1'b0;
        clear_mon();
        for (int k = 0; k < 17; k++) begin
            v = 8'(k);
            send_frame(0, v, -1, 1'b1);
            drive(0, 1'b1, 4);
            if (k == 15) begin
                tests++; if (fill !== 5'd16 || n_ovr != 0) begin fails++; $display("FAIL ovr_at_16: fill %0d overruns %0d want 16 0", fill, n_ovr); end
            end
        end
        tests++; if (fill !== 5'd16) begin fails++; $display("FAIL ovr_fill: got %0d want 16", fill); end
        tests++; if (n_ovr != 1) begin fails++; $display("FAIL ovr_pulse: got %0d cycles want 1", n_ovr); end
        m_ready = 1'b1;
        cyc(20);
        tests++; if (got.size() != 16) begin fails++; $display("FAIL ovr_drain_count: got %0d want 16", got.size()); end
        for (int i = 0; i < 16; i++) begin
            v = 8'(i);
            if (i < got.size()) begin
                tests++; if (got[i] !== v) begin fails++; $display("FAIL ovr_drain_%0d: got %h want %h", i, got[i], v); end
            end
        end
        tests++; if (fill !== 5'd0 || m_valid !== 1'b0) begin fails++; $display("FAIL ovr_empty: fill %0d valid %b want 0 0", fill, m_valid); end
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        clear_mon();
        send_frame(0, 8'h33, -1, 1'b1);
        drive(0, 1'b1, 20);
        tests++; if (fill !== 5'd1) begin fails++; $display("FAIL rstmid_pre_fill: got %0d want 1", fill); end
        drive(0, 1'b0, 16);
        drive(0, 1'b0, 64);
        rst = 1'b1;
        #1;
        tests++; if (m_valid !== 1'b0 || fill !== 5'd0) begin fails++; $display("FAIL rstmid_fifo: valid %b fill %0d want 0 0", m_valid, fill); end
        tests++; if ({perr, ferr, ovr} !== 3'b000) begin fails++; $display("FAIL rstmid_errs: got %b want 000", {perr, ferr, ovr}); end
        rxd = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(5);
        m_ready = 1'b1;
        clear_mon();
        send_frame(0, 8'h12, -1, 1'b1);
        drive(0, 1'b1, 20);
        tests++; if (got.size() != 1 || got[0] !== 8'h12) begin fails++; $display("FAIL rstmid_next: got %0d words head %h, want 1 word 12", got.size(), (got.size() > 0) ? got[0] : 8'hxx); end
        tests++; if (n_perr + n_ferr + n_ovr != 0) begin fails++; $display("FAIL rstmid_next_errs: got %0d want 0", n_perr + n_ferr + n_ovr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_parity();
        test_overrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
